// File: rtl/mux2_arbiter.sv
// Two-requester round-robin arbiter driving a shared output mux, with a
// per-grant burst limit that only applies while the other requester waits.
module mux2_arbiter #(
  parameter int WIDTH = 1,
  parameter int BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             out_valid,
  output logic             sel,
  output logic             gnt0,
  output logic             gnt1,
  output logic [3:0]       beats
);

  typedef enum logic [1:0] {IDLE = 2'd0, G0 = 2'd1, G1 = 2'd2} state_t;

  state_t     state_reg, state_next;
  logic       sel_reg, sel_next;
  logic [3:0] beats_reg, beats_next;
  logic       last_served_reg, last_served_next;

  logic owner;      // index of the requester currently granted
  logic own_req;
  logic other_req;
  logic beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      sel_reg         <= 1'b0;
      beats_reg       <= 4'd0;
      last_served_reg <= 1'b1;
    end else begin
      state_reg       <= state_next;
      sel_reg         <= sel_next;
      beats_reg       <= beats_next;
      last_served_reg <= last_served_next;
    end
  end

  assign owner     = (state_reg == G1);
  assign own_req   = owner ? req1 : req0;
  assign other_req = owner ? req0 : req1;
  assign beat      = out_valid & out_ready;

  always_comb begin
    state_next       = state_reg;
    sel_next         = sel_reg;
    beats_next       = beats_reg;
    last_served_next = last_served_reg;
    case (state_reg)
      IDLE: begin
        // On a tie, the requester not served last time wins.
        if (req0 && (!req1 || last_served_reg)) begin
          state_next = G0;
          sel_next   = 1'b0;
          beats_next = 4'd0;
        end else if (req1) begin
          state_next = G1;
          sel_next   = 1'b1;
          beats_next = 4'd0;
        end
      end
      G0, G1: begin
        if (!own_req) begin
          // Release: hand over directly, or fall back to IDLE keeping sel.
          beats_next       = 4'd0;
          last_served_next = owner;
          if (other_req) begin
            state_next = owner ? G0 : G1;
            sel_next   = ~owner;
          end else begin
            state_next = IDLE;
          end
        end else if (beat) begin
          if (beats_reg == 4'(BURST - 1)) begin
            beats_next = 4'd0;
            if (other_req) begin
              state_next       = owner ? G0 : G1;
              sel_next         = ~owner;
              last_served_next = owner;
            end
          end else begin
            beats_next = beats_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    gnt0      = (state_reg == G0);
    gnt1      = (state_reg == G1);
    out_valid = (gnt0 & req0) | (gnt1 & req1);
    sel       = sel_reg;
    beats     = beats_reg;
    z         = sel_reg ? d1 : d0;
  end

endmodule

// File: tb/tb_mux2_arbiter.sv
// Scoreboard bench for mux2_arbiter: a driver predicts each cycle's outputs
// from a behavioural model and queues them; a monitor pops and compares.
module tb_mux2_arbiter;

  localparam int WIDTH = 8;
  localparam int BURST = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0 = 1'b0;
  logic             req1 = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] d0 = '0;
  logic [WIDTH-1:0] d1 = '0;
  logic [WIDTH-1:0] z;
  logic             out_valid;
  logic             sel;
  logic             gnt0;
  logic             gnt1;
  logic [3:0]       beats;

  mux2_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .d0(d0), .d1(d1),
    .out_ready(out_ready), .z(z), .out_valid(out_valid), .sel(sel),
    .gnt0(gnt0), .gnt1(gnt1), .beats(beats)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic             gnt0;
    logic             gnt1;
    logic             sel;
    logic [3:0]       beats;
    logic             out_valid;
    logic [WIDTH-1:0] z;
  } obs_t;

  obs_t exp_q[$];
  int   tag_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;

  // Reference model: who owns the output (-1 = nobody), beats in this grant,
  // who was served last, and the current mux select.
  int m_owner = -1;
  int m_cnt   = 0;
  int m_last  = 1;
  bit m_sel   = 1'b0;

  task automatic model_edge();
    bit r[2];
    int o;
    r[0] = req0;
    r[1] = req1;
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_last = 1; m_sel = 1'b0;
    end else if (m_owner < 0) begin
      if (r[0] && r[1]) m_owner = 1 - m_last;
      else if (r[0])    m_owner = 0;
      else if (r[1])    m_owner = 1;
      if (m_owner >= 0) begin
        m_sel = (m_owner == 1);
        m_cnt = 0;
      end
    end else begin
      o = 1 - m_owner;
      if (!r[m_owner]) begin
        m_last = m_owner;
        m_cnt  = 0;
        if (r[o]) begin
          m_owner = o;
          m_sel   = (o == 1);
        end else begin
          m_owner = -1;
        end
      end else if (out_ready) begin
        m_cnt++;
        if (m_cnt == BURST) begin
          m_cnt = 0;
          if (r[o]) begin
            m_last  = m_owner;
            m_owner = o;
            m_sel   = (o == 1);
          end
        end
      end
    end
  endtask

  function automatic obs_t predict();
    obs_t e;
    e.gnt0      = (m_owner == 0);
    e.gnt1      = (m_owner == 1);
    e.sel       = m_sel;
    e.beats     = 4'(m_cnt);
    e.out_valid = (m_owner == 0 && req0) || (m_owner == 1 && req1);
    e.z         = m_sel ? d1 : d0;
    return e;
  endfunction

  task automatic step(input bit r_rst, input bit r0, input bit r1, input bit rdy);
    @(posedge clk);
    model_edge();
    cycle++;
    #1;
    rst       = r_rst;
    req0      = r0;
    req1      = r1;
    out_ready = rdy;
    d0        = WIDTH'($urandom);
    d1        = WIDTH'($urandom);
    exp_q.push_back(predict());
    tag_q.push_back(cycle);
  endtask

  task automatic run(input bit r_rst, input bit r0, input bit r1, input bit rdy, input int n);
    for (int i = 0; i < n; i++) step(r_rst, r0, r1, rdy);
  endtask

  // Monitor: compares every presented cycle and logs each accepted beat.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t e;
      obs_t a;
      int   t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = '{gnt0: gnt0, gnt1: gnt1, sel: sel, beats: beats, out_valid: out_valid, z: z};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL cycle %0d outputs: got gnt0=%b gnt1=%b sel=%b beats=%0d valid=%b z=%h, expected gnt0=%b gnt1=%b sel=%b beats=%0d valid=%b z=%h",
                 t, a.gnt0, a.gnt1, a.sel, a.beats, a.out_valid, a.z,
                 e.gnt0, e.gnt1, e.sel, e.beats, e.out_valid, e.z);
      end else if (out_valid && out_ready) begin
        $display("cycle %0d beat: grant=%0d z=%h beats=%0d", t, gnt1 ? 1 : 0, z, beats);
      end
    end
  end

  initial begin
    // Reset held with both requests, then alternation under full readiness.
    run(1, 1, 1, 1, 2);
    run(0, 1, 1, 1, 14);
    // Single requester 1 running past the burst limit alone.
    run(1, 0, 0, 1, 1);
    run(0, 0, 1, 1, 7);
    // Stall in G0 at beats=2 with requester 1 waiting, then resume.
    run(1, 0, 0, 1, 1);
    run(0, 1, 1, 1, 3);
    run(0, 1, 1, 0, 5);
    run(0, 1, 1, 1, 4);
    // Release: G1 hands over to G0 directly, then both drop to IDLE.
    run(1, 0, 0, 1, 1);
    run(0, 0, 1, 1, 2);
    run(0, 1, 0, 1, 2);
    run(0, 0, 0, 1, 3);
    // Reset in the middle of a G1 burst, then a tie.
    run(1, 0, 0, 1, 1);
    run(0, 0, 1, 1, 4);
    run(1, 0, 1, 1, 1);
    run(0, 1, 1, 1, 3);
    // Randomised traffic with occasional resets and stalls.
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
